// File: rtl/embarcacao_pkg.sv
// Shared constants, FSM state and board helpers for ship placement.
// Coordinates are 4-bit codes 1..8; 0 means "not drawn".
package embarcacao_pkg;

  localparam int         TAM_TAB   = 8;
  localparam logic [3:0] COORD_MIN = 4'd1;
  localparam logic [3:0] COORD_MAX = 4'd8;
  localparam int         MAX_CEL   = 5;

  localparam int VALIDO = 0;
  localparam int ORIENT = 1;

  typedef enum logic [1:0] {
    IDLE,
    POSICIONANDO,
    VALIDANDO,
    CONFIRMADO
  } estado_t;

  function automatic int x_lsb(int k);
    return 3 + 8 * k;
  endfunction

  function automatic int y_lsb(int k);
    return 7 + 8 * k;
  endfunction

  // Bit (Y-1)*8 + (X-1) of the occupancy map.
  function automatic logic [5:0] ocup_idx(
    logic [3:0] x,
    logic [3:0] y
  );
    logic [5:0] xx;
    logic [5:0] yy;
    xx = {2'b00, x} - 6'd1;
    yy = {2'b00, y} - 6'd1;
    return (yy << 3) + xx;
  endfunction

  function automatic logic [3:0] cel_x(
    logic [3:0] x0,
    logic       vert,
    logic [2:0] k
  );
    return vert ? x0 : x0 + {1'b0, k};
  endfunction

  function automatic logic [3:0] cel_y(
    logic [3:0] y0,
    logic       vert,
    logic [2:0] k
  );
    return vert ? y0 + {1'b0, k} : y0;
  endfunction

  function automatic logic [63:0] monta_palavra(
    logic [3:0] x0,
    logic [3:0] y0,
    logic       vert,
    logic       valido,
    int         len
  );
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < MAX_CEL; k++) begin
      if (k < len) begin
        w[x_lsb(k) +: 4] = cel_x(x0, vert, 3'(k));
        w[y_lsb(k) +: 4] = cel_y(y0, vert, 3'(k));
      end
    end
    w[ORIENT] = vert;
    w[VALIDO] = valido;
    return w;
  endfunction

  function automatic logic [63:0] mascara(
    logic [3:0] x0,
    logic [3:0] y0,
    logic       vert,
    int         len
  );
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < MAX_CEL; k++) begin
      if (k < len) begin
        m[ocup_idx(cel_x(x0, vert, 3'(k)),
                   cel_y(y0, vert, 3'(k)))] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/posicionador_embarcacao_detector_borda.sv
// Rising-edge detector for W synchronous levels.
// Ports: clk, reset, sinal[W] in; borda[W] out (combinational pulse).
module detector_borda #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sinal,
  output logic [W-1:0] borda
);

  // Resets to ones: a level held through reset gives no edge.
  logic [W-1:0] ant;

  always_ff @(posedge clk) begin
    if (reset) ant <= '1;
    else       ant <= sinal;
  end

  assign borda = sinal & ~ant;

endmodule

// File: rtl/posicionador_embarcacao.sv
// Ship-placement controller: buttons -> packed ship-position word.
// Ports: clk, reset, iniciar, btn_*, ocupado in; word, pronto, erro, ocupado_proprio out.
module posicionador_embarcacao
  import embarcacao_pkg::*;
#(
  parameter int TAMANHO = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        btn_cima,
  input  logic        btn_baixo,
  input  logic        btn_esq,
  input  logic        btn_dir,
  input  logic        btn_girar,
  input  logic        btn_confirma,
  input  logic [63:0] ocupado,
  output logic [63:0] posicoesEmbarcacao,
  output logic        pronto,
  output logic        erro,
  output logic [63:0] ocupado_proprio
);

  localparam logic [3:0] EXT  = 4'(TAMANHO - 1);
  localparam logic [2:0] NCEL = 3'(TAMANHO);

  // Event order: confirma, girar, cima, baixo, esq, dir.
  logic [5:0] ev;

  detector_borda #(.W(6)) u_borda (
    .clk   (clk),
    .reset (reset),
    .sinal ({btn_confirma, btn_girar, btn_cima,
             btn_baixo, btn_esq, btn_dir}),
    .borda (ev)
  );

  estado_t    estado, est_n;
  logic [3:0] x0, y0, x_n, y_n;
  logic       vert, v_n;
  logic [2:0] idx, idx_n;
  logic       hit, hit_n;
  logic       pronto_n, erro_n;

  logic ok_cima, ok_baixo, ok_esq, ok_dir, ok_girar;
  logic hit_now;

  always_comb begin
    // Last-cell coordinate after the move must stay <= 8.
    ok_cima  = (y0 + 4'd1 + (vert ? EXT : 4'd0))
               <= COORD_MAX;
    ok_dir   = (x0 + 4'd1 + (vert ? 4'd0 : EXT))
               <= COORD_MAX;
    ok_baixo = y0 > COORD_MIN;
    ok_esq   = x0 > COORD_MIN;
    ok_girar = vert ? ((x0 + EXT) <= COORD_MAX)
                    : ((y0 + EXT) <= COORD_MAX);
    hit_now  = ocupado[ocup_idx(cel_x(x0, vert, idx),
                                cel_y(y0, vert, idx))];
  end

  always_comb begin
    est_n    = estado;
    x_n      = x0;
    y_n      = y0;
    v_n      = vert;
    idx_n    = idx;
    hit_n    = hit;
    pronto_n = 1'b0;
    erro_n   = 1'b0;
    if (iniciar) begin
      est_n = POSICIONANDO;
      x_n   = COORD_MIN;
      y_n   = COORD_MIN;
      v_n   = 1'b0;
    end else begin
      unique case (estado)
        IDLE: ;
        POSICIONANDO: begin
          priority case (1'b1)
            ev[5]: begin
              est_n = VALIDANDO;
              idx_n = '0;
              hit_n = 1'b0;
            end
            ev[4]: if (ok_girar) v_n = ~vert;
            ev[3]: if (ok_cima)  y_n = y0 + 4'd1;
            ev[2]: if (ok_baixo) y_n = y0 - 4'd1;
            ev[1]: if (ok_esq)   x_n = x0 - 4'd1;
            ev[0]: if (ok_dir)   x_n = x0 + 4'd1;
            default: ;
          endcase
        end
        VALIDANDO: begin
          // One cell per cycle, then one decision cycle.
          if (idx == NCEL) begin
            est_n    = hit ? POSICIONANDO : CONFIRMADO;
            erro_n   = hit;
            pronto_n = ~hit;
          end else begin
            hit_n = hit | hit_now;
            idx_n = idx + 3'd1;
          end
        end
        CONFIRMADO: ;
        default: est_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado             <= IDLE;
      x0                 <= COORD_MIN;
      y0                 <= COORD_MIN;
      vert               <= 1'b0;
      idx                <= '0;
      hit                <= 1'b0;
      pronto             <= 1'b0;
      erro               <= 1'b0;
      posicoesEmbarcacao <= '0;
      ocupado_proprio    <= '0;
    end else begin
      estado <= est_n;
      x0     <= x_n;
      y0     <= y_n;
      vert   <= v_n;
      idx    <= idx_n;
      hit    <= hit_n;
      pronto <= pronto_n;
      erro   <= erro_n;
      posicoesEmbarcacao <= (est_n == IDLE) ? '0 :
        monta_palavra(x_n, y_n, v_n,
                      est_n == CONFIRMADO, TAMANHO);
      ocupado_proprio <= (est_n == CONFIRMADO) ?
        mascara(x_n, y_n, v_n, TAMANHO) : '0;
    end
  end

endmodule

// File: tb/tb_posicionador_embarcacao.sv
// Self-checking bench for posicionador_embarcacao.
// Directed sequence plus randomized run against a behavioural model.
module tb_posicionador_embarcacao;

  localparam int T = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        iniciar;
  logic [5:0]  btn;
  logic [63:0] ocupado;
  logic [63:0] word;
  logic [63:0] own;
  logic        pronto;
  logic        erro;

  posicionador_embarcacao #(.TAMANHO(T)) dut (
    .clk                (clk),
    .reset              (reset),
    .iniciar            (iniciar),
    .btn_cima           (btn[3]),
    .btn_baixo          (btn[2]),
    .btn_esq            (btn[1]),
    .btn_dir            (btn[0]),
    .btn_girar          (btn[4]),
    .btn_confirma       (btn[5]),
    .ocupado            (ocupado),
    .posicoesEmbarcacao (word),
    .pronto             (pronto),
    .erro               (erro),
    .ocupado_proprio    (own)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string n, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h t=%0t",
               n, got, exp, $time);
    end
  endtask

  localparam int S_IDLE = 0;
  localparam int S_POS  = 1;
  localparam int S_VAL  = 2;
  localparam int S_CONF = 3;

  int         m_st = S_IDLE;
  int         ax = 1;
  int         ay = 1;
  bit         av = 0;
  int         cnt = 0;
  bit         mhit = 0;
  bit         mp = 0;
  bit         me = 0;
  logic [5:0] mprev = '1;

  function automatic int cx_of(int k);
    return ax + (av ? 0 : k);
  endfunction

  function automatic int cy_of(int k);
    return ay + (av ? k : 0);
  endfunction

  function automatic bit legal(int x, int y, bit v);
    for (int k = 0; k < T; k++) begin
      int cx;
      int cy;
      cx = x + (v ? 0 : k);
      cy = y + (v ? k : 0);
      if (cx < 1 || cx > 8 || cy < 1 || cy > 8)
        return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit collides();
    for (int k = 0; k < T; k++)
      if (ocupado[(cy_of(k) - 1) * 8 + cx_of(k) - 1])
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_word();
    logic [63:0] w;
    w = '0;
    if (m_st != S_IDLE) begin
      for (int k = 0; k < T; k++) begin
        w[3 + 8 * k +: 4] = 4'(cx_of(k));
        w[7 + 8 * k +: 4] = 4'(cy_of(k));
      end
      w[1] = av;
      w[0] = (m_st == S_CONF);
    end
    return w;
  endfunction

  function automatic logic [63:0] exp_own();
    logic [63:0] m;
    m = '0;
    if (m_st == S_CONF)
      for (int k = 0; k < T; k++)
        m[(cy_of(k) - 1) * 8 + cx_of(k) - 1] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) begin
    logic [5:0] ev;
    mp = 0;
    me = 0;
    if (reset) begin
      m_st  = S_IDLE;
      mprev = '1;
    end else begin
      ev    = btn & ~mprev;
      mprev = btn;
      if (iniciar) begin
        m_st = S_POS;
        ax = 1;
        ay = 1;
        av = 0;
      end else if (m_st == S_POS) begin
        if (ev[5]) begin
          m_st = S_VAL;
          cnt  = T + 1;
          mhit = collides();
        end else if (ev[4]) begin
          if (legal(ax, ay, !av)) av = !av;
        end else if (ev[3]) begin
          if (legal(ax, ay + 1, av)) ay++;
        end else if (ev[2]) begin
          if (legal(ax, ay - 1, av)) ay--;
        end else if (ev[1]) begin
          if (legal(ax - 1, ay, av)) ax--;
        end else if (ev[0]) begin
          if (legal(ax + 1, ay, av)) ax++;
        end
      end else if (m_st == S_VAL) begin
        cnt--;
        if (cnt == 0) begin
          if (mhit) begin
            me   = 1;
            m_st = S_POS;
          end else begin
            mp   = 1;
            m_st = S_CONF;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_word", word, exp_word());
    chk("model_own", own, exp_own());
    chk("model_pronto", {63'b0, pronto}, {63'b0, mp});
    chk("model_erro", {63'b0, erro}, {63'b0, me});
  end

  task automatic press(int b);
    btn[b] = 1'b1;
    @(negedge clk);
    btn[b] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    iniciar = 1'b0;
    btn     = 6'b000001;
    ocupado = '0;
    repeat (3) @(negedge clk);
    chk("reset_word", word, 64'h0);
    chk("reset_pronto", {63'b0, pronto}, 64'h0);
    chk("reset_erro", {63'b0, erro}, 64'h0);
    chk("reset_own", own, 64'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_word", word, 64'h0);

    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    chk("iniciar_word", word, 64'h9088);
    @(negedge clk);
    chk("dir_held_no_move", word, 64'h9088);
    btn[0] = 1'b0;
    @(negedge clk);

    for (int i = 1; i <= 8; i++) begin
      press(0);
      if (i == 6) chk("dir6", word, 64'hC0B8);
    end
    chk("dir8_clamped", word, 64'hC0B8);
    repeat (7) press(3);
    chk("cima7", word, 64'h44438);
    press(4);
    chk("girar_top_ignored", word, 64'h44438);

    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    chk("restart", word, 64'h9088);
    ocupado = 64'h2;
    btn[5] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      btn[5] = 1'b0;
      chk("erro_timing", {63'b0, erro}, 64'(i == 4));
      chk("pronto_low", {63'b0, pronto}, 64'h0);
    end
    chk("erro_keeps_preview", word, 64'h9088);

    press(3);
    chk("cima_after_erro", word, 64'h11108);
    btn[5] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      btn[5] = 1'b0;
      chk("pronto_timing", {63'b0, pronto}, 64'(i == 4));
      chk("erro_low", {63'b0, erro}, 64'h0);
    end
    chk("confirmed_word", word, 64'h11109);
    chk("own_cells", own, 64'h300);
    press(0);
    chk("frozen", word, 64'h11109);

    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    btn[5] = 1'b1;
    btn[0] = 1'b1;
    @(negedge clk);
    btn = '0;
    chk("conf_dir_same", word, 64'h9088);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid_val", word, 64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_pronto", {63'b0, pronto}, 64'h0);
      chk("abort_erro", {63'b0, erro}, 64'h0);
    end

    for (int c = 0; c < 4000; c++) begin
      reset   = ($urandom_range(0, 299) == 0);
      iniciar = ($urandom_range(0, 49) == 0);
      btn     = 6'($urandom) & 6'($urandom);
      btn[5]  = ($urandom_range(0, 15) == 0);
      if (!btn[5] && m_st != S_VAL &&
          $urandom_range(0, 15) == 0)
        ocupado = {$urandom, $urandom}
                & {$urandom, $urandom}
                & {$urandom, $urandom};
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
